// File: rtl/reg_ownership_manager.sv
`default_nettype none
// =============================================================================
// Module      : reg_ownership_manager
// Description : Tracks which processor holds the newest copy of each register,
//               muxes the unified register view, and handles multi-register
//               claims with busy marking and per-processor sync pulses.
//               Optional macro: REG_MGR_CONFLICT_CHECK_EN (stall overlapping claims).
// Revision    : 1.0 - initial release
// =============================================================================
module reg_ownership_manager #(
   parameter int PROC_NUM        = 2,
   parameter int REGISTER_AMOUNT = 32,
   parameter int REGISTER_WIDTH  = 64,
   parameter int MAX_CLAIM       = 3,
   parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT),
   parameter int PROC_IDX_WIDTH  = ($clog2(PROC_NUM) > 1) ? $clog2(PROC_NUM) : 1
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic [PROC_NUM*REGISTER_AMOUNT*REGISTER_WIDTH-1:0]  processor_registers,
   input  logic [PROC_NUM-1:0]                                 processor_idle,
   input  logic [PROC_NUM-1:0]                                 claim_valid,
   input  logic [PROC_NUM*2-1:0]                               claim_count,
   input  logic [PROC_NUM*MAX_CLAIM*REG_CTN_WIDTH-1:0]         claim_regs,
   output logic [PROC_NUM-1:0]                                 claim_ready,
   input  logic [REGISTER_WIDTH-1:0]                           ra_register,
   output logic [REGISTER_AMOUNT*REGISTER_WIDTH-1:0]           registers_renew,
   output logic [REGISTER_AMOUNT-1:0]                          processing_register_table,
   output logic [REGISTER_AMOUNT*PROC_IDX_WIDTH-1:0]           owner_table,
   output logic [PROC_NUM-1:0]                                 synchronization_processor,
   output logic                                                synchronized_processors
);

   localparam logic [REG_CTN_WIDTH-1:0] c_RA_IDX = REG_CTN_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRE_UPDATING = 2'd1,
      UPDATING     = 2'd2
   } state_t;

   state_t                    r_state      [PROC_NUM];
   state_t                    w_state_nxt  [PROC_NUM];
   logic [REG_CTN_WIDTH-1:0]  r_claim_idx  [PROC_NUM][MAX_CLAIM];
   logic [MAX_CLAIM-1:0]      r_claim_mask [PROC_NUM];
   logic [REGISTER_AMOUNT-1:0] r_busy;
   logic [PROC_IDX_WIDTH-1:0] r_owner      [REGISTER_AMOUNT];
   logic [PROC_NUM-1:0]       r_synced;
   logic [PROC_NUM-1:0]       r_sync_pulse;

   logic [REG_CTN_WIDTH-1:0]  w_req_idx    [PROC_NUM][MAX_CLAIM];
   logic [MAX_CLAIM-1:0]      w_req_mask   [PROC_NUM];
   logic [PROC_NUM-1:0]       w_ready;
   logic [PROC_NUM-1:0]       w_accept;
   logic [PROC_NUM-1:0]       w_commit;
   logic [PROC_NUM-1:0]       w_sync_fire;
   logic                      w_all_idle;
   logic                      w_unused_ra_slots;

   // A count of 0 still claims slot 0; counts above MAX_CLAIM clip naturally.
   always_comb begin
      for (int p = 0; p < PROC_NUM; p++) begin
         for (int k = 0; k < MAX_CLAIM; k++) begin
            w_req_idx[p][k]  = claim_regs[(p*MAX_CLAIM + k)*REG_CTN_WIDTH +: REG_CTN_WIDTH];
            w_req_mask[p][k] = (k == 0) || (k < int'(claim_count[p*2 +: 2]));
         end
      end
   end

   always_comb begin
      w_all_idle = 1'b1;
      for (int p = 0; p < PROC_NUM; p++) begin
         if (r_state[p] != IDLE) begin
            w_all_idle = 1'b0;
         end
      end

      for (int p = 0; p < PROC_NUM; p++) begin
         w_ready[p] = (r_state[p] == IDLE);
`ifdef REG_MGR_CONFLICT_CHECK_EN
         // Stall on busy indices, or on indices a lower processor takes this cycle.
         for (int k = 0; k < MAX_CLAIM; k++) begin
            if (w_req_mask[p][k]) begin
               if (r_busy[w_req_idx[p][k]]) begin
                  w_ready[p] = 1'b0;
               end
               for (int q = 0; q < p; q++) begin
                  for (int j = 0; j < MAX_CLAIM; j++) begin
                     if (claim_valid[q] && w_ready[q] && w_req_mask[q][j] &&
                         (w_req_idx[q][j] == w_req_idx[p][k])) begin
                        w_ready[p] = 1'b0;
                     end
                  end
               end
            end
         end
`endif
         w_accept[p]    = claim_valid[p] && w_ready[p];
         w_commit[p]    = (r_state[p] == UPDATING) && processor_idle[p];
         w_sync_fire[p] = (r_state[p] == IDLE) && !claim_valid[p] && !r_synced[p] &&
                          w_all_idle && processor_idle[p];

         w_state_nxt[p] = r_state[p];
         case (r_state[p])
            IDLE: begin
               if (w_accept[p]) begin
                  w_state_nxt[p] = PRE_UPDATING;
               end
            end
            PRE_UPDATING: begin
               if (!processor_idle[p]) begin
                  w_state_nxt[p] = UPDATING;
               end
            end
            UPDATING: begin
               if (processor_idle[p]) begin
                  w_state_nxt[p] = IDLE;
               end
            end
            default: begin
               w_state_nxt[p] = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < PROC_NUM; p++) begin
            r_state[p] <= IDLE;
         end
      end else begin
         for (int p = 0; p < PROC_NUM; p++) begin
            r_state[p] <= w_state_nxt[p];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < PROC_NUM; p++) begin
            r_claim_mask[p] <= '0;
            for (int k = 0; k < MAX_CLAIM; k++) begin
               r_claim_idx[p][k] <= '0;
            end
         end
      end else begin
         for (int p = 0; p < PROC_NUM; p++) begin
            if (w_accept[p]) begin
               r_claim_mask[p] <= w_req_mask[p];
               for (int k = 0; k < MAX_CLAIM; k++) begin
                  r_claim_idx[p][k] <= w_req_idx[p][k];
               end
            end
         end
      end
   end

   // Later assignments win: ascending processor order gives the highest index
   // ownership, and busy-set after busy-clear lets a new claim win.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy       <= '0;
         r_synced     <= '1;
         r_sync_pulse <= '0;
         for (int r = 0; r < REGISTER_AMOUNT; r++) begin
            r_owner[r] <= '0;
         end
      end else begin
         for (int p = 0; p < PROC_NUM; p++) begin
            if (w_commit[p]) begin
               for (int k = 0; k < MAX_CLAIM; k++) begin
                  if (r_claim_mask[p][k]) begin
                     r_busy[r_claim_idx[p][k]] <= 1'b0;
                     if (r_claim_idx[p][k] != c_RA_IDX) begin
                        r_owner[r_claim_idx[p][k]] <= PROC_IDX_WIDTH'(p);
                     end
                  end
               end
            end
         end
         for (int p = 0; p < PROC_NUM; p++) begin
            if (w_accept[p]) begin
               for (int k = 0; k < MAX_CLAIM; k++) begin
                  if (w_req_mask[p][k]) begin
                     r_busy[w_req_idx[p][k]] <= 1'b1;
                  end
               end
            end
         end
         for (int p = 0; p < PROC_NUM; p++) begin
            if (w_sync_fire[p]) begin
               r_synced[p] <= 1'b1;
            end
            for (int q = 0; q < PROC_NUM; q++) begin
               if ((q != p) && w_commit[q]) begin
                  r_synced[p] <= 1'b0;
               end
            end
         end
         r_sync_pulse <= w_sync_fire;
      end
   end

   for (genvar r = 0; r < REGISTER_AMOUNT; r++) begin : g_reg_view
      assign owner_table[r*PROC_IDX_WIDTH +: PROC_IDX_WIDTH] = r_owner[r];
      if (r == 1) begin : g_ra
         assign registers_renew[r*REGISTER_WIDTH +: REGISTER_WIDTH] = ra_register;
      end else begin : g_mux
         assign registers_renew[r*REGISTER_WIDTH +: REGISTER_WIDTH] =
            processor_registers[(int'(r_owner[r])*REGISTER_AMOUNT + r)*REGISTER_WIDTH +: REGISTER_WIDTH];
      end
   end

   // Register-1 slots of the register files are never selected.
   assign w_unused_ra_slots          = ^processor_registers;

   assign claim_ready                = w_ready;
   assign processing_register_table  = r_busy;
   assign synchronization_processor  = r_sync_pulse;
   assign synchronized_processors    = &r_synced;

endmodule
`default_nettype wire
